// File: rtl/func_sweep_ctrl.sv
// Sweeps all 16 input vectors through two combinational realisations of one
// 4-input function, holding each vector SETTLE cycles and sampling on the next.
// The sweep takes 16*(SETTLE+1) cycles from start to done.
// start/abort are single-cycle controls with no backpressure; abort wins over start.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   start, abort       host control: begin sweep / cancel sweep in progress
//   w, x, y, z         registered stimulus to both function instances (vec[3:0])
//   fa, fb             outputs of implementation A (NAND) and B (NOR)
//   busy, done, pass   sweep status; pass is meaningful only while done
//   err_cnt            number of mismatching vectors in the current/last sweep
//   first_err_vec/_valid  lowest mismatching vector and its qualifier
//   truth_tbl          bit i holds fa as sampled for vector i
module func_sweep_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        w,
    output logic        x,
    output logic        y,
    output logic        z,
    input  logic        fa,
    input  logic        fb,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_cnt,
    output logic [3:0]  first_err_vec,
    output logic        first_err_valid,
    output logic [15:0] truth_tbl
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    // Last settle count before sampling; SETTLE is legal in 1..15.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] VEC_LAST    = 4'hF;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  vec;
    logic [3:0]  settle_cnt;

    // Control strobes decoded by the FSM for the datapath registers.
    logic        sweep_begin;
    logic        sweep_abort;
    logic        sweep_sample;

    logic        mismatch;
    logic [4:0]  err_cnt_nxt;

    assign mismatch    = fa ^ fb;
    assign err_cnt_nxt = err_cnt + 5'(mismatch);

    // The stimulus is the vector register itself, so it only moves on the
    // edge leaving SAMPLE (or on start/abort/reset).
    assign w = vec[3];
    assign x = vec[2];
    assign y = vec[1];
    assign z = vec[0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and status decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        sweep_begin  = 1'b0;
        sweep_abort  = 1'b0;
        sweep_sample = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state)
            S_IDLE: begin
                // abort has nothing to cancel here
                if (start) begin
                    sweep_begin = 1'b1;
                    state_nxt   = S_SETTLE;
                end
            end

            S_SETTLE: begin
                busy = 1'b1;
                if (abort) begin
                    sweep_abort = 1'b1;
                    state_nxt   = S_IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = S_SAMPLE;
                end
            end

            S_SAMPLE: begin
                busy = 1'b1;
                // An abort in the sample cycle discards that vector's result.
                if (abort) begin
                    sweep_abort = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    sweep_sample = 1'b1;
                    state_nxt    = (vec == VEC_LAST) ? S_DONE : S_SETTLE;
                end
            end

            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    sweep_begin = 1'b1;
                    state_nxt   = S_SETTLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sweep datapath: vector, settle counter, results
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vec             <= 4'd0;
            settle_cnt      <= 4'd0;
            err_cnt         <= 5'd0;
            first_err_vec   <= 4'd0;
            first_err_valid <= 1'b0;
            truth_tbl       <= 16'd0;
            pass            <= 1'b0;
        end else if (sweep_begin) begin
            vec             <= 4'd0;
            settle_cnt      <= 4'd0;
            err_cnt         <= 5'd0;
            first_err_vec   <= 4'd0;
            first_err_valid <= 1'b0;
            truth_tbl       <= 16'd0;
            pass            <= 1'b0;
        end else if (sweep_abort) begin
            // Partial results stay visible until the next start.
            vec        <= 4'd0;
            settle_cnt <= 4'd0;
            pass       <= 1'b0;
        end else if (sweep_sample) begin
            truth_tbl[vec] <= fa;
            if (mismatch) begin
                err_cnt <= err_cnt_nxt;
                if (!first_err_valid) begin
                    first_err_vec   <= vec;
                    first_err_valid <= 1'b1;
                end
            end
            if (vec == VEC_LAST) begin
                // The terminal vector's own mismatch counts toward pass.
                pass <= (err_cnt_nxt == 5'd0);
            end else begin
                vec        <= vec + 4'd1;
                settle_cnt <= 4'd0;
            end
        end else if (state == S_SETTLE) begin
            settle_cnt <= settle_cnt + 4'd1;
        end
    end

endmodule

// File: doc/func_sweep_ctrl.md
Name: func_sweep_ctrl

Overview:
- Sequencer that exhaustively drives a 4-input combinational function unit through all 16 input vectors.
- Compares two implementations of the same function (NAND-only and NOR-only realisations) vector by vector and captures the 16-entry truth table.
- Reports mismatch count, first failing vector and pass/fail status.
- Sits between a test/config host (start/abort) and the two function instances, which are purely combinational.

Parameters:
- SETTLE, 2, cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  in  1  clock, all state updated on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  begin sweep; sampled only in IDLE or DONE
- abort  in  1  cancel sweep in progress; return to IDLE
- w  out  1  datapath input, = vec[3], registered
- x  out  1  datapath input, = vec[2], registered
- y  out  1  datapath input, = vec[1], registered
- z  out  1  datapath input, = vec[0], registered
- fa  in  1  output of implementation A (NAND)
- fb  in  1  output of implementation B (NOR)
- busy  out  1  high in SETTLE/SAMPLE
- done  out  1  high in DONE, held until next start, abort or rst
- pass  out  1  valid when done: err_cnt==0
- err_cnt  out  5  mismatching vectors, 0..16, no saturation needed
- first_err_vec  out  4  index of lowest mismatching vector
- first_err_valid  out  1  at least one mismatch recorded this sweep
- truth_tbl  out  16  bit i = fa sampled for vector i

Behaviour:
- Reset: state IDLE; w,x,y,z=0; busy=0; done=0; pass=0; err_cnt=0; first_err_vec=0; first_err_valid=0; truth_tbl=0. Reset overrides every other input and takes effect mid-sweep.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> vec<=0, settle_cnt<=0, clear err_cnt, first_err_*, truth_tbl, pass; go to SETTLE.
  - abort is ignored in IDLE.
- SETTLE:
  - w..z reflect vec; settle_cnt increments each cycle.
  - When settle_cnt==SETTLE-1 -> SAMPLE.
- SAMPLE (one cycle):
  - truth_tbl[vec]<=fa.
  - If fa!=fb: err_cnt++; if !first_err_valid, set first_err_vec<=vec and first_err_valid<=1.
  - If vec==15 -> DONE with pass<=(final err_cnt==0). The final count includes this vector.
  - Otherwise vec<=vec+1, settle_cnt<=0, -> SETTLE.
- DONE:
  - Outputs held; w..z hold 4'b1111.
  - start=1 restarts exactly as from IDLE and clears done in the same edge.
- Timing: for start sampled at edge k, done rises at edge k+16*(SETTLE+1). With SETTLE=2, that is 48 cycles.
- Input changes: each vector change occurs on the edge leaving SAMPLE, so fa/fb get SETTLE full cycles to settle.
- start while busy: ignored, with no restart and no effect on counters.
- abort while busy: -> IDLE next edge. busy=0, done=0, pass=0; w..z<=0. err_cnt, first_err_* and truth_tbl keep their partial values until the next start.
- abort and start both high in the same cycle while busy: abort wins.
- vec wrap: vec never wraps; 15 is the terminal vector.

Test Plan:
- fa=fb=w&x (bench model), SETTLE=2, pulse start -> done at start edge +48; truth_tbl=16'hF000, err_cnt=0, pass=1, first_err_valid=0.
- fa=w&x, fb=fa^(vec==5)^(vec==9) -> err_cnt=2, first_err_vec=5, first_err_valid=1, pass=0, truth_tbl=16'hF000.
- fb=~fa for all vectors -> err_cnt=16, first_err_vec=0, pass=0.
- start pulsed again at vector 7 while busy -> no restart, same done time and results as a single start.
- abort at vector 6 -> IDLE next edge with busy=0, done=0, w..z=0; a later start gives a full 48-cycle clean sweep. Repeat with rst mid-sweep -> all outputs at reset values the next cycle.
- SETTLE=1: w..z step 0..15 every 2 cycles. Then start in DONE -> immediate restart with done=0 and counters cleared on that edge.
